// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between the fetch and decode stages: a DEPTH-entry FIFO of {instr, pc}.
// Optional stall statistics counter enabled by defining FETCH_QUEUE_STATS_EN.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     fetch_valid,
  input  logic [7:0]               fetch_instr,
  input  logic [7:0]               fetch_pc,
  output logic                     fetch_ready,
  output logic                     dec_valid,
  output logic [7:0]               dec_instr,
  output logic [7:0]               dec_pc,
  input  logic                     dec_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [7:0]               stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

  occ_e          state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    instrMem [DEPTH];
  logic [7:0]    pcMem    [DEPTH];
  logic          doPush;
  logic          doPop;

  // Handshake flags come only from registered occupancy, never from dec_ready.
  assign fetch_ready = (state_q != FULL);
  assign dec_valid   = (state_q != EMPTY);
  assign doPush      = fetch_valid & fetch_ready;
  assign doPop       = dec_valid & dec_ready;
  assign count       = count_q;
  assign dec_instr   = dec_valid ? instrMem[head_q] : 8'h00;
  assign dec_pc      = dec_valid ? pcMem[head_q]    : 8'h00;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doPush) tail_d = tail_q + PW'(1);
      if (doPop)  head_d = head_q + PW'(1);
      if (doPush && !doPop) begin
        count_d = count_q + CW'(1);
      end else if (!doPush && doPop) begin
        count_d = count_q - CW'(1);
      end
    end
    if (count_d == '0) begin
      state_d = EMPTY;
    end else if (count_d == FULL_CNT) begin
      state_d = FULL;
    end else begin
      state_d = PARTIAL;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; the read muxes hide anything outside the valid window.
  always_ff @(posedge clock) begin
    if (doPush && !flush) begin
      instrMem[tail_q] <= fetch_instr;
      pcMem[tail_q]    <= fetch_pc;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [7:0] stall_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (fetch_valid && !fetch_ready && (stall_q != 8'hFF)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
